// File: rtl/lc3_ext_pkg.sv
// Shared constants for the LC-3 immediate extractor: mode encodings, field widths, output width limits.
package lc3_ext_pkg;

    localparam int IR_W   = 16;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] EXT_SEXT5  = 3'd0;
    localparam logic [MODE_W-1:0] EXT_SEXT6  = 3'd1;
    localparam logic [MODE_W-1:0] EXT_SEXT9  = 3'd2;
    localparam logic [MODE_W-1:0] EXT_SEXT11 = 3'd3;
    localparam logic [MODE_W-1:0] EXT_ZEXT8  = 3'd4;
    localparam logic [MODE_W-1:0] EXT_ZEXT16 = 3'd5;

    localparam int FW_IMM5   = 5;
    localparam int FW_OFF6   = 6;
    localparam int FW_PCOFF9 = 9;
    localparam int FW_PCOFF11 = 11;
    localparam int FW_TRAP8  = 8;
    localparam int FW_WORD16 = 16;

    localparam int OUT_W_MIN = 16;
    localparam int OUT_W_MAX = 32;

    function automatic bit out_w_legal(input int w);
        return (w >= OUT_W_MIN) && (w <= OUT_W_MAX);
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Producer/consumer handshake bundle around the immediate extender buffer.
interface imm_extend_pipe_if
    import lc3_ext_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [IR_W-1:0]   in_ir;
    logic [MODE_W-1:0] in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, in_ir, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_err, out_tag
    );

    modport master (
        output in_valid, in_ir, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_tag
    );
endinterface

// File: rtl/imm_extend_field.sv
// Combinational field extraction and sign/zero extension of an LC-3 instruction word.
module imm_extend_field
    import lc3_ext_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [IR_W-1:0]   ir_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              err_o
);

    // Size casts of signed slices replicate the field MSB; unsigned casts zero-fill.
    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (mode_i)
            EXT_SEXT5:  data_o = OUT_W'($signed(ir_i[FW_IMM5-1:0]));
            EXT_SEXT6:  data_o = OUT_W'($signed(ir_i[FW_OFF6-1:0]));
            EXT_SEXT9:  data_o = OUT_W'($signed(ir_i[FW_PCOFF9-1:0]));
            EXT_SEXT11: data_o = OUT_W'($signed(ir_i[FW_PCOFF11-1:0]));
            EXT_ZEXT8:  data_o = OUT_W'(ir_i[FW_TRAP8-1:0]);
            EXT_ZEXT16: data_o = OUT_W'(ir_i[FW_WORD16-1:0]);
            default:    err_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: extends on the input side, then buffers {data, err, tag} in a 2-entry FIFO.
module imm_extend_pipe
    import lc3_ext_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    imm_extend_pipe_if.slave bus
);

    if (!out_w_legal(OUT_W)) begin : g_out_w_check
        $error("imm_extend_pipe: OUT_W must lie in 16..32");
    end

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    imm_extend_field #(.OUT_W(OUT_W)) u_field (
        .ir_i   (bus.in_ir),
        .mode_i (bus.in_mode),
        .data_o (ext_data),
        .err_o  (ext_err)
    );

    logic [OUT_W-1:0] data_q [2];
    logic [1:0]       err_q;
    logic [TAG_W-1:0] tag_q  [2];

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       in_ready, out_valid, push, pop;

    // Ready depends on count alone, so there is no combinational out_ready -> in_ready path.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid & in_ready & ~rst;
    assign pop       = out_valid & bus.out_ready & ~rst;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= ext_data;
            err_q[wr_ptr_q]  <= ext_err;
            tag_q[wr_ptr_q]  <= bus.in_tag;
        end
    end

    // Empty buffer reads as zero so stale entries never leak onto the outputs.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    assign bus.out_err   = out_valid ? err_q[rd_ptr_q]  : 1'b0;
    assign bus.out_tag   = out_valid ? tag_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: one 16-bit and one 32-bit instance share stimulus; expected values are hand-derived.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_ir = '0;
    logic [2:0]  in_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.OUT_W(16), .TAG_W(4)) if16 ();
    imm_extend_pipe_if #(.OUT_W(32), .TAG_W(4)) if32 ();

    assign if16.in_valid  = in_valid;
    assign if16.in_ir     = in_ir;
    assign if16.in_mode   = in_mode;
    assign if16.in_tag    = in_tag;
    assign if16.out_ready = out_ready;
    assign if32.in_valid  = in_valid;
    assign if32.in_ir     = in_ir;
    assign if32.in_mode   = in_mode;
    assign if32.in_tag    = in_tag;
    assign if32.out_ready = out_ready;

    imm_extend_pipe #(.OUT_W(16), .TAG_W(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    imm_extend_pipe #(.OUT_W(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single accept, check head on both widths, then pop.
    task automatic one_word(input string name, input logic [15:0] ir, input logic [2:0] mode,
                            input logic [3:0] tag, input logic [15:0] exp16,
                            input logic [31:0] exp32, input logic exp_err);
        in_valid = 1'b1; in_ir = ir; in_mode = mode; in_tag = tag;
        tick();
        in_valid = 1'b0;
        check({name, "_valid"}, 32'(if16.out_valid), 32'd1);
        check({name, "_d16"},   32'(if16.out_data),  32'(exp16));
        check({name, "_d32"},   if32.out_data,       exp32);
        check({name, "_err"},   32'(if16.out_err),   32'(exp_err));
        check({name, "_tag"},   32'(if32.out_tag),   32'(tag));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_drained"}, 32'(if16.out_valid), 32'd0);
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(if16.out_valid), 32'd0);
        check("rst_ready", 32'(if16.in_ready),  32'd1);
        check("rst_data",  if32.out_data,       32'd0);

        // Latency: not visible before the accepting edge, visible right after it
        in_valid = 1'b1; in_ir = 16'h001F; in_mode = 3'd0; in_tag = 4'h3;
        #2;
        check("lat_before", 32'(if16.out_valid), 32'd0);
        in_valid = 1'b0;
        one_word("sext5_neg", 16'h001F, 3'd0, 4'h3, 16'hFFFF, 32'hFFFF_FFFF, 1'b0);
        one_word("sext5_pos", 16'hFFEF, 3'd0, 4'h4, 16'h000F, 32'h0000_000F, 1'b0);
        one_word("sext6",     16'h0020, 3'd1, 4'h5, 16'hFFE0, 32'hFFFF_FFE0, 1'b0);
        one_word("sext9",     16'h0110, 3'd2, 4'h1, 16'hFF10, 32'hFFFF_FF10, 1'b0);
        one_word("sext11",    16'h0400, 3'd3, 4'h2, 16'hFC00, 32'hFFFF_FC00, 1'b0);
        one_word("zext8",     16'h0110, 3'd4, 4'h6, 16'h0010, 32'h0000_0010, 1'b0);
        one_word("zext16",    16'h0110, 3'd5, 4'h7, 16'h0110, 32'h0000_0110, 1'b0);
        one_word("zext16_hi", 16'h8001, 3'd5, 4'h8, 16'h8001, 32'h0000_8001, 1'b0);
        one_word("mode6",     16'hFFFF, 3'd6, 4'hA, 16'h0000, 32'h0000_0000, 1'b1);
        one_word("mode7",     16'h1234, 3'd7, 4'hB, 16'h0000, 32'h0000_0000, 1'b1);

        // Backpressure: third word waits until space frees up
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd5; in_ir = 16'h0001; in_tag = 4'h1;
        tick();
        check("bp_ready1", 32'(if16.in_ready), 32'd1);
        in_ir = 16'h0002; in_tag = 4'h2;
        tick();
        check("bp_full", 32'(if16.in_ready), 32'd0);
        in_ir = 16'h0003; in_tag = 4'h3;
        tick();
        check("bp_hold_ready", 32'(if16.in_ready), 32'd0);
        check("bp_hold_data",  32'(if16.out_data), 32'h0001);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_data",  32'(if16.out_data), 32'h0002);
        check("bp_pop1_ready", 32'(if16.in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_third_data", 32'(if16.out_data), 32'h0003);
        check("bp_third_tag",  32'(if16.out_tag),  32'h3);
        tick();
        check("bp_empty", 32'(if16.out_valid), 32'd0);

        // Streaming: one result per cycle with no bubbles
        in_valid = 1'b1; in_mode = 3'd3; in_ir = 16'h0400;
        for (int i = 0; i < 8; i++) begin
            in_tag = 4'(i);
            tick();
            check("stream_valid", 32'(if16.out_valid), 32'd1);
            check("stream_data",  32'(if16.out_data),  32'h0000_FC00);
            check("stream_tag",   32'(if16.out_tag),   32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", 32'(if16.out_valid), 32'd0);

        // Reset while full discards both entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd0; in_ir = 16'h0001; in_tag = 4'h5;
        tick();
        in_tag = 4'h6;
        tick();
        check("full_before_rst", 32'(if16.in_ready), 32'd0);
        rst = 1'b1; in_tag = 4'hE;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_mid_valid", 32'(if16.out_valid), 32'd0);
        check("rst_mid_data",  if32.out_data,       32'd0);
        check("rst_mid_err",   32'(if16.out_err),   32'd0);
        check("rst_mid_tag",   32'(if16.out_tag),   32'd0);
        check("rst_mid_ready", 32'(if16.in_ready),  32'd1);
        one_word("post_rst", 16'h00AB, 3'd4, 4'h9, 16'h00AB, 32'h0000_00AB, 1'b0);
        tick();
        check("post_rst_no_stale", 32'(if16.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
